// File: rtl/t03_icache_pkg.sv
// Shared types and address-split helper for the instruction-cache line-fill block.
package t03_icache_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Controller states: serve hits in IDLE, fetch one whole line in REFILL.
    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Field widths of a byte address split into tag / index / word offset.
    typedef struct packed {
        int off_w;
        int idx_w;
        int tag_w;
    } addr_split_t;

    // log2 of a power-of-two value.
    function automatic int log2_pow2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Word offset, set index and tag widths for a given cache geometry.
    function automatic addr_split_t calc_addr_split(input int num_sets, input int words_per_line);
        addr_split_t s;
        s.off_w = log2_pow2(words_per_line);
        s.idx_w = log2_pow2(num_sets);
        s.tag_w = ADDR_W - 2 - s.off_w - s.idx_w;
        return s;
    endfunction

endpackage

// File: rtl/t03_icache_store.sv
// Tag, valid and data storage for a direct-mapped instruction cache.
// One combinational read port (indexed by the lookup address) and one
// write port that stores a word and, optionally, the line's tag and valid bit.
module t03_icache_store
    import t03_icache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).idx_w-1:0] rd_idx,
    input  logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).off_w-1:0] rd_off,
    output logic                                                   rd_valid,
    output logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).tag_w-1:0] rd_tag,
    output logic [DATA_W-1:0]                                      rd_word,
    input  logic                                                   clear_all,
    input  logic                                                   wr_en,
    input  logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).idx_w-1:0] wr_idx,
    input  logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).off_w-1:0] wr_off,
    input  logic [DATA_W-1:0]                                      wr_data,
    input  logic                                                   wr_tag_en,
    input  logic [calc_addr_split(NUM_SETS, WORDS_PER_LINE).tag_w-1:0] wr_tag,
    input  logic                                                   wr_valid
);

    localparam addr_split_t SPLIT = calc_addr_split(NUM_SETS, WORDS_PER_LINE);
    localparam int OFF_W = SPLIT.off_w;
    localparam int IDX_W = SPLIT.idx_w;
    localparam int TAG_W = SPLIT.tag_w;

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [DATA_W-1:0]   data_mem [NUM_SETS*WORDS_PER_LINE];

    // Valid-bit update: line install/invalidate, then a global clear on flush.
    always_comb begin
        // NOTE: valid_d gets its default before any branch so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        if (wr_tag_en) valid_d[wr_idx] = wr_valid;
        if (clear_all) valid_d = '0;
    end

    // Valid bits are the only storage that must come up clean.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // Tag and data arrays: write-only on the clock, no reset.
    always_ff @(posedge clk) begin
        // NOTE: tag/data arrays are not reset; a line is only ever read through its valid bit.
        if (wr_en)     data_mem[{wr_idx, wr_off}] <= wr_data;
        if (wr_tag_en) tag_mem[wr_idx]            <= wr_tag;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_word  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/t03_icache_line_fill.sv
// Direct-mapped instruction cache with whole-line refill from a word-wide
// backing memory. Hits return in the request cycle; misses fetch the line
// one word per mem_ack and then retry the lookup.
// Optional feature: define T03_ICACHE_STATS_EN to build saturating hit/miss
// counters; otherwise hit_count and miss_count are tied to zero.
module t03_icache_line_fill
    import t03_icache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam addr_split_t SPLIT = calc_addr_split(NUM_SETS, WORDS_PER_LINE);
    localparam int OFF_W = SPLIT.off_w;
    localparam int IDX_W = SPLIT.idx_w;
    localparam int TAG_W = SPLIT.tag_w;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    // Request address fields; the byte-lane bits are ignored.
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             addr_unused;

    assign req_off     = cpu_addr[2 +: OFF_W];
    assign req_idx     = cpu_addr[2 + OFF_W +: IDX_W];
    assign req_tag     = cpu_addr[2 + OFF_W + IDX_W +: TAG_W];
    assign addr_unused = ^cpu_addr[1:0];

    // Controller state: the line being refilled and the next word to fetch.
    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             flush_pend_q, flush_pend_d;

    // Storage interface.
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_word;
    logic              clear_all;
    logic              wr_en;
    logic              wr_tag_en;
    logic              wr_valid;

    logic lookup_hit;
    logic lookup_miss;
    logic tag_match;
    logic flush_seen;

    t03_icache_store #(
        .NUM_SETS       (NUM_SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (req_idx),
        .rd_off    (req_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .clear_all (clear_all),
        .wr_en     (wr_en),
        .wr_idx    (idx_q),
        .wr_off    (cnt_q),
        .wr_data   (mem_rdata),
        .wr_tag_en (wr_tag_en),
        .wr_tag    (tag_q),
        .wr_valid  (wr_valid)
    );

    assign tag_match   = rd_valid && (rd_tag == req_tag);
    assign lookup_hit  = (state_q == IDLE) && cpu_req && tag_match;
    assign lookup_miss = (state_q == IDLE) && cpu_req && !tag_match;
    assign flush_seen  = flush_pend_q || flush;

    // Hits are answered from the lookup in the same cycle; outside a hit the bus is quiet.
    assign cpu_ready = lookup_hit;
    assign cpu_data  = lookup_hit ? rd_word : '0;

    // The memory request follows the state flop, so reset drops it at once.
    assign mem_req  = (state_q == REFILL);
    assign mem_addr = mem_req ? {tag_q, idx_q, cnt_q, 2'b00} : '0;

    // Next-state logic: start a refill on a miss, write one word per ack, finish on the last word.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        clear_all    = 1'b0;
        wr_en        = 1'b0;
        wr_tag_en    = 1'b0;
        wr_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                clear_all = flush;
                if (lookup_miss) begin
                    state_d = REFILL;
                    tag_d   = req_tag;
                    idx_d   = req_idx;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                // A flush here cannot abort the memory handshake; remember it for the end.
                if (flush) flush_pend_d = 1'b1;
                if (mem_ack) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        wr_tag_en    = 1'b1;
                        wr_valid     = !flush_seen;
                        clear_all    = flush_seen;
                        flush_pend_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset abandons any partial refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef T03_ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating statistics, cleared by any flush request.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (lookup_hit && (hit_cnt_q != CNT_MAX))   hit_cnt_d  = hit_cnt_q + 32'd1;
            if (lookup_miss && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_t03_icache_line_fill.sv
// Directed bench for t03_icache_line_fill: a memory responder checks every
// refill address against a queue of expected addresses, and each fetch pushes
// its expected data and latency to a queue popped when cpu_ready appears.
module tb_t03_icache_line_fill;

    localparam int          WPL     = 4;
    localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
    localparam logic [31:0] NO_ADDR = 32'hDEAD_BEEF;
    localparam int          TIMEOUT = 200;
`ifdef T03_ICACHE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          latency;
    } cpu_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_data;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          ack_delay = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] exp_mem_q[$];
    cpu_exp_t    exp_cpu_q[$];

    t03_icache_line_fill #(
        .NUM_SETS       (16),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_data   (cpu_data),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ KEY;
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < WPL; i++) exp_mem_q.push_back(base + 32'(i * 4));
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_hits"},   hit_count,  STATS_EN ? 32'(exp_hits)   : 32'd0);
        check({tag, "_misses"}, miss_count, STATS_EN ? 32'(exp_misses) : 32'd0);
    endtask

    // Issue one fetch, hold it until cpu_ready, compare data and latency.
    task automatic fetch(input string tag, input logic [31:0] addr, input int lat, input int flush_at);
        int       cyc;
        bit       done;
        cpu_exp_t e;
        @(negedge clk);
        cpu_addr = addr;
        cpu_req  = 1'b1;
        exp_cpu_q.push_back('{mem_word(addr), lat});
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            flush = (cyc == flush_at);
            #1;
            if (cpu_ready) begin
                e = exp_cpu_q.pop_front();
                check({tag, "_data"},    cpu_data,   e.data);
                check({tag, "_latency"}, 32'(cyc),   32'(e.latency));
                done = 1'b1;
            end else if (cyc >= TIMEOUT) begin
                e = exp_cpu_q.pop_front();
                check({tag, "_timeout"}, 32'(cpu_ready), 32'd1);
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        flush   = 1'b0;
        #1;
        check({tag, "_idle_ready"}, 32'(cpu_ready), 32'd0);
        check({tag, "_idle_data"},  cpu_data, 32'd0);
        check({tag, "_refill_words_left"}, 32'(exp_mem_q.size()), 32'd0);
    endtask

    // Backing memory: acks after ack_delay wait cycles, checks address order and stability.
    initial begin
        int          wait_cnt;
        logic [31:0] held_addr;
        logic [31:0] exp_a;
        wait_cnt  = 0;
        held_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (mem_req) begin
                if (wait_cnt == 0) held_addr = mem_addr;
                else check("mem_addr_stable", mem_addr, held_addr);
                if (wait_cnt >= ack_delay) begin
                    if (exp_mem_q.size() > 0) exp_a = exp_mem_q.pop_front();
                    else exp_a = NO_ADDR;
                    check("mem_addr", mem_addr, exp_a);
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr ^ KEY;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Directed sequence.
    initial begin
        rst      = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        #2;
        check("rst_cpu_ready",  32'(cpu_ready), 32'd0);
        check("rst_cpu_data",   cpu_data,       32'd0);
        check("rst_mem_req",    32'(mem_req),   32'd0);
        check("rst_mem_addr",   mem_addr,       32'd0);
        check_stats("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Cold miss, one ack per cycle: 0x40..0x4C then a hit at cycle 5.
        push_line(32'h40);
        fetch("cold_40", 32'h40, WPL + 1, -1);
        exp_hits = 1; exp_misses = 1;
        check_stats("cold_40");

        // Same line, different word: same-cycle hit, no memory traffic.
        fetch("hit_48", 32'h48, 0, -1);
        exp_hits = 2;
        check_stats("hit_48");

        // Conflicting tag in the same set evicts the line; the original then misses again.
        push_line(32'h440);
        fetch("conflict_440", 32'h440, WPL + 1, -1);
        exp_hits = 3; exp_misses = 2;
        push_line(32'h40);
        fetch("remiss_40", 32'h40, WPL + 1, -1);
        exp_hits = 4; exp_misses = 3;
        check_stats("remiss_40");

        // Slow memory: three wait cycles per word.
        ack_delay = 3;
        push_line(32'h80);
        fetch("slow_84", 32'h84, 4 * WPL + 1, -1);
        ack_delay = 0;
        exp_hits = 5; exp_misses = 4;
        check_stats("slow_84");

        // Flush in IDLE alongside a hit: hit served, counters cleared, line gone.
        fetch("flush_hit_40", 32'h40, 0, 0);
        exp_hits = 0; exp_misses = 0;
        check_stats("flush_hit_40");

        // Flush during the second refill word: refill finishes, retry misses and refetches.
        push_line(32'h40);
        push_line(32'h40);
        fetch("flush_refill_40", 32'h40, 2 * (WPL + 1), 2);
        exp_hits = 1; exp_misses = 1;
        check_stats("flush_refill_40");
        fetch("hit_44", 32'h44, 0, -1);
        exp_hits = 2;
        check_stats("hit_44");

        // Reset in the middle of a refill.
        @(negedge clk);
        cpu_addr = 32'h200;
        cpu_req  = 1'b1;
        push_line(32'h200);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_mem_req",   32'(mem_req),   32'd0);
        check("midrst_mem_addr",  mem_addr,       32'd0);
        check("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
        cpu_req = 1'b0;
        exp_mem_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_hits = 0; exp_misses = 0;
        check_stats("midrst");

        // All lines invalid after reset.
        push_line(32'h40);
        fetch("post_rst_40", 32'h40, WPL + 1, -1);
        exp_hits = 1; exp_misses = 1;
        check_stats("post_rst_40");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
